// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package   : mips_ctrl_pkg
// Purpose   : Shared definitions for the multicycle MIPS control unit:
//             state encoding, aluop codes, opcodes and ALU control codes.
// Revision  : 1.0  initial release
// ============================================================================
package mips_ctrl_pkg;

  // FSM state codes. Codes 12..15 are unused and recover to S_FETCH.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  // aluop: how the ALU decoder chooses the operation
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU control codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

endpackage : mips_ctrl_pkg
`default_nettype wire

// File: rtl/aludec.sv
`default_nettype none
// ============================================================================
// Module    : aludec
// Purpose   : ALU decoder. Maps aluop (and funct for R-type) to the 4-bit
//             ALU control code.
// Revision  : 1.0  initial release
// ============================================================================
module aludec
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] i_aluop,
  input  logic [5:0] i_funct,
  output logic [3:0] o_alucontrol
);

  // Fixed add/sub for address and branch math, funct field for R-type
  always_comb begin
    o_alucontrol = ALU_AND;
    case (i_aluop)
      ALUOP_ADD:   o_alucontrol = ALU_ADD;
      ALUOP_SUB:   o_alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          6'b100000: o_alucontrol = ALU_ADD;
          6'b100010: o_alucontrol = ALU_SUB;
          6'b100100: o_alucontrol = ALU_AND;
          6'b100101: o_alucontrol = ALU_OR;
          6'b101010: o_alucontrol = ALU_SLT;
          default:   o_alucontrol = ALU_AND;
        endcase
      end
      default:     o_alucontrol = ALU_AND;
    endcase
  end

endmodule : aludec
`default_nettype wire

// File: rtl/controller_multi.sv
`default_nettype none
// ============================================================================
// Module    : controller_multi
// Purpose   : Multicycle MIPS control unit. Moore FSM that sequences the
//             shared multicycle datapath and stalls on mem_ready.
// Options   : CTRL_MULTI_BNE_EN - adds BNE through the BRANCH state.
// Revision  : 1.0  initial release
// ============================================================================
module controller_multi
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [3:0] alucontrol,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] ST_FETCH    = S_FETCH;
  localparam logic [3:0] ST_DECODE   = S_DECODE;
  localparam logic [3:0] ST_MEMADR   = S_MEMADR;
  localparam logic [3:0] ST_MEMRD    = S_MEMRD;
  localparam logic [3:0] ST_MEMWB    = S_MEMWB;
  localparam logic [3:0] ST_MEMWR    = S_MEMWR;
  localparam logic [3:0] ST_EXECUTE  = S_EXECUTE;
  localparam logic [3:0] ST_ALUWB    = S_ALUWB;
  localparam logic [3:0] ST_BRANCH   = S_BRANCH;
  localparam logic [3:0] ST_ADDIEXEC = S_ADDIEXEC;
  localparam logic [3:0] ST_ADDIWB   = S_ADDIWB;
  localparam logic [3:0] ST_JUMP     = S_JUMP;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic [3:0] w_st;        // state driving the outputs (FETCH while in reset)
  logic [3:0] w_dec_next;
  logic       w_op_legal;
  logic       w_is_bne;
  logic [1:0] w_aluop;
  logic       w_irwrite, w_pcwrite, w_memwrite, w_regwrite;
  logic       w_branch, w_bne, w_done, w_illegal;

`ifdef CTRL_MULTI_BNE_EN
  logic r_bne;

  // Remember in DECODE whether the branch is a BNE; IR is stable afterwards
  always_ff @(posedge clk) begin
    if (reset)
      r_bne <= 1'b0;
    else if (r_state == ST_DECODE)
      r_bne <= (op == OP_BNE);
  end

  assign w_is_bne = r_bne;
`else
  assign w_is_bne = 1'b0;
`endif

  // Opcode dispatch target out of DECODE
  always_comb begin
    w_dec_next = ST_FETCH;
    w_op_legal = 1'b1;
    case (op)
      OP_LW, OP_SW: w_dec_next = ST_MEMADR;
      OP_RTYPE:     w_dec_next = ST_EXECUTE;
      OP_BEQ:       w_dec_next = ST_BRANCH;
`ifdef CTRL_MULTI_BNE_EN
      OP_BNE:       w_dec_next = ST_BRANCH;
`endif
      OP_ADDI:      w_dec_next = ST_ADDIEXEC;
      OP_J:         w_dec_next = ST_JUMP;
      default: begin
        w_dec_next = ST_FETCH;
        w_op_legal = 1'b0;
      end
    endcase
  end

  // Next-state logic
  always_comb begin
    w_next = ST_FETCH;
    case (r_state)
      ST_FETCH:    w_next = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE:   w_next = w_dec_next;
      ST_MEMADR:   w_next = (op == OP_SW) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD:    w_next = mem_ready ? ST_MEMWB : ST_MEMRD;
      ST_MEMWR:    w_next = mem_ready ? ST_FETCH : ST_MEMWR;
      ST_EXECUTE:  w_next = ST_ALUWB;
      ST_ADDIEXEC: w_next = ST_ADDIWB;
      default:     w_next = ST_FETCH;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset)
      r_state <= ST_FETCH;
    else
      r_state <= w_next;
  end

  // Moore outputs; during reset the selects follow FETCH
  always_comb begin
    w_st       = reset ? ST_FETCH : r_state;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    w_aluop    = ALUOP_ADD;
    w_irwrite  = 1'b0;
    w_pcwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_regwrite = 1'b0;
    w_branch   = 1'b0;
    w_bne      = 1'b0;
    w_done     = 1'b0;
    w_illegal  = 1'b0;
    case (w_st)
      ST_FETCH: begin
        alusrcb   = 2'b01;
        w_irwrite = mem_ready;
        w_pcwrite = mem_ready;
      end
      ST_DECODE: begin
        alusrcb   = 2'b11;
        w_illegal = ~w_op_legal;
        w_done    = ~w_op_legal;
      end
      ST_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ST_MEMRD: iord = 1'b1;
      ST_MEMWB: begin
        w_regwrite = 1'b1;
        memtoreg   = 1'b1;
        w_done     = 1'b1;
      end
      ST_MEMWR: begin
        iord       = 1'b1;
        w_memwrite = 1'b1;
        w_done     = mem_ready;
      end
      ST_EXECUTE: begin
        alusrca = 1'b1;
        w_aluop = ALUOP_FUNCT;
      end
      ST_ALUWB: begin
        w_regwrite = 1'b1;
        regdst     = 1'b1;
        w_done     = 1'b1;
      end
      ST_BRANCH: begin
        alusrca  = 1'b1;
        w_aluop  = ALUOP_SUB;
        pcsrc    = 2'b01;
        w_branch = ~w_is_bne;
        w_bne    = w_is_bne;
        w_done   = 1'b1;
      end
      ST_ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ST_ADDIWB: begin
        w_regwrite = 1'b1;
        w_done     = 1'b1;
      end
      ST_JUMP: begin
        pcsrc     = 2'b10;
        w_pcwrite = 1'b1;
        w_done    = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables and pulses are held off for the whole reset cycle
  assign irwrite    = w_irwrite  & ~reset;
  assign memwrite   = w_memwrite & ~reset;
  assign regwrite   = w_regwrite & ~reset;
  assign instr_done = w_done     & ~reset;
  assign illegal    = w_illegal  & ~reset;
  assign pcen       = (w_pcwrite | (w_branch & zero) | (w_bne & ~zero)) & ~reset;
  assign state      = r_state;

  aludec u_aludec (
    .i_aluop      (w_aluop),
    .i_funct      (funct),
    .o_alucontrol (alucontrol)
  );

endmodule : controller_multi
`default_nettype wire

// File: tb/tb_controller_multi.sv
`default_nettype none
// ============================================================================
// Module    : tb_controller_multi
// Purpose   : Scoreboard bench for controller_multi. The driver walks each
//             instruction through its architectural steps and queues the
//             expected per-cycle outputs; a monitor compares every cycle.
// Revision  : 1.0  initial release
// ============================================================================
module tb_controller_multi;

  typedef struct packed {
    logic [3:0] st;
    logic       iord, irwrite, memwrite, memtoreg, regdst, regwrite, alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcen;
    logic [3:0] aluctl;
    logic       done, ill;
  } out_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       iord, irwrite, memwrite, memtoreg, regdst, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic       pcen;
  logic [3:0] alucontrol;
  logic       instr_done, illegal;
  logic [3:0] state;

  out_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic tb_end = 1'b0;

  always #5 clk = ~clk;

  controller_multi dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .iord       (iord),
    .irwrite    (irwrite),
    .memwrite   (memwrite),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .pcen       (pcen),
    .alucontrol (alucontrol),
    .instr_done (instr_done),
    .illegal    (illegal),
    .state      (state)
  );

  // Reference: quiet cycle in a given step, ALU doing an add
  function automatic out_t base(input logic [3:0] s);
    out_t o;
    o        = '0;
    o.st     = s;
    o.aluctl = 4'b0010;
    return o;
  endfunction

  function automatic logic [3:0] funct_op(input logic [5:0] f);
    case (f)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      default:   return 4'b0000;
    endcase
  endfunction

  // 0 LW, 1 SW, 2 R, 3 BEQ, 4 BNE, 5 ADDI, 6 J, 7 illegal
  function automatic int classify(input logic [5:0] o);
    case (o)
      6'b100011: return 0;
      6'b101011: return 1;
      6'b000000: return 2;
      6'b000100: return 3;
`ifdef CTRL_MULTI_BNE_EN
      6'b000101: return 4;
`endif
      6'b001000: return 5;
      6'b000010: return 6;
      default:   return 7;
    endcase
  endfunction

  function automatic logic pickz(input int zsel);
    return (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
  endfunction

  task automatic step(input out_t e);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Drive one instruction. fw/mw: mem_ready=0 cycles in FETCH / memory step
  // (-1 = random). zsel: zero flag (-1 = random). abort: reset in MEMRD.
  task automatic run_instr(input logic [5:0] iop, input logic [5:0] ifn,
                           input int fw, input int mw, input int zsel,
                           input bit abort);
    out_t e;
    int   nfw, nmw, kind;
    nfw = (fw < 0) ? (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0) : fw;
    nmw = (mw < 0) ? (($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0) : mw;
    reset = 1'b0;
    op    = iop;
    funct = ifn;
    kind  = classify(iop);
    // instruction fetch
    for (int k = 0; k <= nfw; k++) begin
      mem_ready = (k == nfw);
      zero      = pickz(zsel);
      e = base(4'd0); e.alusrcb = 2'b01;
      e.irwrite = mem_ready; e.pcen = mem_ready;
      step(e);
    end
    // decode
    mem_ready = 1'($urandom_range(0, 1));
    zero      = pickz(zsel);
    e = base(4'd1); e.alusrcb = 2'b11;
    if (kind == 7) begin e.done = 1'b1; e.ill = 1'b1; end
    step(e);
    case (kind)
      0, 1: begin
        mem_ready = 1'($urandom_range(0, 1)); zero = pickz(zsel);
        e = base(4'd2); e.alusrca = 1'b1; e.alusrcb = 2'b10;
        step(e);
        for (int k = 0; k <= nmw; k++) begin
          mem_ready = (k == nmw);
          zero      = pickz(zsel);
          if (kind == 0 && abort && k == 1) begin
            reset = 1'b1; mem_ready = 1'b0;
            e = base(4'd3); e.alusrcb = 2'b01;
            step(e);
            reset = 1'b0;
            return;
          end
          if (kind == 0) begin
            e = base(4'd3); e.iord = 1'b1;
          end else begin
            e = base(4'd5); e.iord = 1'b1; e.memwrite = 1'b1; e.done = mem_ready;
          end
          step(e);
        end
        if (kind == 0) begin
          mem_ready = 1'($urandom_range(0, 1)); zero = pickz(zsel);
          e = base(4'd4); e.regwrite = 1'b1; e.memtoreg = 1'b1; e.done = 1'b1;
          step(e);
        end
      end
      2: begin
        mem_ready = 1'($urandom_range(0, 1)); zero = pickz(zsel);
        e = base(4'd6); e.alusrca = 1'b1; e.aluctl = funct_op(ifn);
        step(e);
        mem_ready = 1'($urandom_range(0, 1)); zero = pickz(zsel);
        e = base(4'd7); e.regwrite = 1'b1; e.regdst = 1'b1; e.done = 1'b1;
        step(e);
      end
      3, 4: begin
        mem_ready = 1'($urandom_range(0, 1)); zero = pickz(zsel);
        e = base(4'd8); e.alusrca = 1'b1; e.aluctl = 4'b0110;
        e.pcsrc = 2'b01; e.done = 1'b1;
        e.pcen = (kind == 3) ? zero : ~zero;
        step(e);
      end
      5: begin
        mem_ready = 1'($urandom_range(0, 1)); zero = pickz(zsel);
        e = base(4'd9); e.alusrca = 1'b1; e.alusrcb = 2'b10;
        step(e);
        mem_ready = 1'($urandom_range(0, 1)); zero = pickz(zsel);
        e = base(4'd10); e.regwrite = 1'b1; e.done = 1'b1;
        step(e);
      end
      6: begin
        mem_ready = 1'($urandom_range(0, 1)); zero = pickz(zsel);
        e = base(4'd11); e.pcsrc = 2'b10; e.pcen = 1'b1; e.done = 1'b1;
        step(e);
      end
      default: ;
    endcase
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] o;
    case ($urandom_range(0, 7))
      0: return 6'b100011;
      1: return 6'b101011;
      2: return 6'b000000;
      3: return 6'b000100;
      4: return 6'b000101;
      5: return 6'b001000;
      6: return 6'b000010;
      default: begin
        for (int a = 0; a < 20; a++) begin
          o = 6'($urandom);
          if (classify(o) == 7) return o;
        end
        return 6'b111111;
      end
    endcase
  endfunction

  function automatic logic [5:0] pick_funct();
    case ($urandom_range(0, 5))
      0: return 6'b100000;
      1: return 6'b100010;
      2: return 6'b100100;
      3: return 6'b100101;
      4: return 6'b101010;
      default: return 6'($urandom);
    endcase
  endfunction

  // Driver
  initial begin
    out_t e;
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      mem_ready = 1'($urandom_range(0, 1));
      zero      = 1'($urandom_range(0, 1));
      e = base(4'd0); e.alusrcb = 2'b01;
      step(e);
    end
    run_instr(6'b100011, 6'd0,      0, 0, -1, 1'b0);  // LW
    run_instr(6'b101011, 6'd0,      0, 3, -1, 1'b0);  // SW, 3 wait cycles
    run_instr(6'b000000, 6'b101010, 0, 0, -1, 1'b0);  // slt
    run_instr(6'b000000, 6'b111111, 0, 0, -1, 1'b0);  // unknown funct
    run_instr(6'b000100, 6'd0,      0, 0,  1, 1'b0);  // BEQ taken
    run_instr(6'b000100, 6'd0,      0, 0,  0, 1'b0);  // BEQ not taken
    run_instr(6'b000010, 6'd0,      0, 0, -1, 1'b0);  // J
    run_instr(6'b111111, 6'd0,      0, 0, -1, 1'b0);  // illegal
    run_instr(6'b000101, 6'd0,      0, 0,  0, 1'b0);  // BNE / illegal
    run_instr(6'b000101, 6'd0,      0, 0,  1, 1'b0);
    run_instr(6'b001000, 6'd0,      2, 0, -1, 1'b0);  // ADDI after fetch stall
    run_instr(6'b100011, 6'd0,      0, 3, -1, 1'b1);  // reset inside MEMRD
    run_instr(6'b100011, 6'd0,      1, 1, -1, 1'b0);
    for (int n = 0; n < 200; n++)
      run_instr(pick_op(), pick_funct(), -1, -1, -1, 1'b0);
    tb_end = 1'b1;
  end

  // Monitor: one expected record per cycle, compared mid-cycle
  initial begin
    out_t e, a;
    while (!tb_end) begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        a = '{st: state, iord: iord, irwrite: irwrite, memwrite: memwrite,
              memtoreg: memtoreg, regdst: regdst, regwrite: regwrite,
              alusrca: alusrca, alusrcb: alusrcb, pcsrc: pcsrc, pcen: pcen,
              aluctl: alucontrol, done: instr_done, ill: illegal};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs t=%0t exp_state=%0d got=%h want=%h", $time, e.st, a, e);
        end
      end
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got=%0d want=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule : tb_controller_multi
`default_nettype wire
